wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural state sink at the far end of the MEM/WB writeback interface of the MIPS pipeline.
- Holds 32 GPRs plus the HI/LO pair and accepts one GPR write and one HI/LO write per cycle from the MEM/WB stage register.
- Serves two combinational GPR read ports and a HI/LO read port to ID/EX.
- Write-to-read bypass inside the block, so a value written in cycle N is visible to a read issued in cycle N.

Parameters:
REG_ADDR_WIDTH, 5, GPR index width
REG_DATA_WIDTH, 32, GPR / HI / LO data width
REG_NUM, 32, number of GPRs (must equal 2**REG_ADDR_WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w_reg_addr_in  input  REG_ADDR_WIDTH  GPR write index from MEM/WB
w_reg_data_in  input  REG_DATA_WIDTH  GPR write data
w_reg_en_in  input  1  GPR write enable
hi_regs_in  input  REG_DATA_WIDTH  HI write data
lo_regs_in  input  REG_DATA_WIDTH  LO write data
hilo_wen_in  input  1  HI/LO write enable (writes both)
r1_en  input  1  read port 1 enable
r1_addr  input  REG_ADDR_WIDTH  read port 1 index
r1_data  output  REG_DATA_WIDTH  read port 1 data (combinational)
r2_en  input  1  read port 2 enable
r2_addr  input  REG_ADDR_WIDTH  read port 2 index
r2_data  output  REG_DATA_WIDTH  read port 2 data (combinational)
hi_data_out  output  REG_DATA_WIDTH  current HI (combinational, bypassed)
lo_data_out  output  REG_DATA_WIDTH  current LO (combinational, bypassed)

Behaviour:
- Reset: rst_n low clears all GPRs, HI and LO to 0 immediately, independent of clk. While rst_n is low:
  - every output reads 0;
  - writes are ignored;
  - bypass is suppressed.
- GPR write: on posedge clk with rst_n high, w_reg_en_in=1 and w_reg_addr_in!=0, GPR[w_reg_addr_in] <= w_reg_data_in. Writes to index 0 are discarded; GPR[0] is constant 0.
- GPR read priority, per port, evaluated in order:
  1. rst_n low -> 0.
  2. rX_en=0 -> 0.
  3. rX_addr=0 -> 0.
  4. w_reg_en_in=1 and w_reg_addr_in==rX_addr -> w_reg_data_in (same-cycle bypass).
  5. Otherwise -> GPR[rX_addr].
- Both read ports are independent. Both may hit the same index and both may bypass in the same cycle.
- HI/LO write: on posedge clk with rst_n high and hilo_wen_in=1, HI <= hi_regs_in and LO <= lo_regs_in (always as a pair).
- HI/LO read:
  - hilo_wen_in=1 -> hi_regs_in / lo_regs_in (bypass);
  - otherwise the stored values;
  - 0 while rst_n is low.
- A GPR write and a HI/LO write in the same cycle are independent and both commit.
- Read latency: 0 cycles (combinational). Write latency: 1 edge, with bypass making it visible in the same cycle.
- Reset asserted mid-cycle while a write is pending: the write is lost and state is 0. The first edge after rst_n rises performs normal writes.
- No X propagation: unwritten GPRs read 0 after reset.

Test Plan:
- Reset, then read r1_addr=5 and r2_addr=31 with both enables high -> r1_data=0, r2_data=0, hi_data_out=0, lo_data_out=0.
- Write GPR3=0xDEADBEEF at edge N; read r1_addr=3 in cycle N+1 with no write active -> 0xDEADBEEF. r1_en=0 in that cycle -> r1_data=0.
- In the same cycle drive w_reg_en_in=1, w_reg_addr_in=7, w_reg_data_in=0x12345678 and r1_addr=r2_addr=7 -> both ports 0x12345678 before the edge. After the edge, with the write removed, both ports still read 0x12345678.
- Write to index 0 with data 0xFFFFFFFF -> bypass suppressed and stored value unchanged; r1_addr=0 reads 0 in the same cycle and in all later cycles.
- hilo_wen_in=1, hi_regs_in=0xAAAA0000, lo_regs_in=0x0000BBBB -> outputs match in the same cycle and hold after the enable drops. In the same cycle a GPR write to GPR9=0x5 also commits, and r1_addr=9 returns 0x5.
- Load GPR4=0x77 and HI=0x1, then pulse rst_n low between clock edges -> all outputs go to 0 without a clock edge. After release, r1_addr=4 reads 0 and hi_data_out reads 0.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS writeback register file: 32 GPRs plus HI/LO, with same-cycle write-to-read bypass
// Two combinational GPR read ports and a HI/LO read port; GPR[0] is hardwired to zero.
module wb_regfile #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_NUM        = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
   input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
   input  logic                      w_reg_en_in,
   input  logic [REG_DATA_WIDTH-1:0] hi_regs_in,
   input  logic [REG_DATA_WIDTH-1:0] lo_regs_in,
   input  logic                      hilo_wen_in,
   input  logic                      r1_en,
   input  logic [REG_ADDR_WIDTH-1:0] r1_addr,
   output logic [REG_DATA_WIDTH-1:0] r1_data,
   input  logic                      r2_en,
   input  logic [REG_ADDR_WIDTH-1:0] r2_addr,
   output logic [REG_DATA_WIDTH-1:0] r2_data,
   output logic [REG_DATA_WIDTH-1:0] hi_data_out,
   output logic [REG_DATA_WIDTH-1:0] lo_data_out
);

   logic [REG_DATA_WIDTH-1:0] r_gpr [REG_NUM];
   logic [REG_DATA_WIDTH-1:0] r_hi;
   logic [REG_DATA_WIDTH-1:0] r_lo;
   logic                      w_gpr_wr;

   // Index 0 is never committed, so r_gpr[0] stays at its reset value of zero.
   assign w_gpr_wr = w_reg_en_in && (w_reg_addr_in != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_gpr[i] <= '0;
         end
      end else if (w_gpr_wr) begin
         r_gpr[w_reg_addr_in] <= w_reg_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (hilo_wen_in) begin
         r_hi <= hi_regs_in;
         r_lo <= lo_regs_in;
      end
   end

   // Read priority: reset, disabled port, index 0, same-cycle bypass, stored value.
   always_comb begin
      r1_data = '0;
      if (!rst_n || !r1_en || (r1_addr == '0)) begin
         r1_data = '0;
      end else if (w_reg_en_in && (w_reg_addr_in == r1_addr)) begin
         r1_data = w_reg_data_in;
      end else begin
         r1_data = r_gpr[r1_addr];
      end
   end

   always_comb begin
      r2_data = '0;
      if (!rst_n || !r2_en || (r2_addr == '0)) begin
         r2_data = '0;
      end else if (w_reg_en_in && (w_reg_addr_in == r2_addr)) begin
         r2_data = w_reg_data_in;
      end else begin
         r2_data = r_gpr[r2_addr];
      end
   end

   always_comb begin
      hi_data_out = '0;
      lo_data_out = '0;
      if (!rst_n) begin
         hi_data_out = '0;
         lo_data_out = '0;
      end else if (hilo_wen_in) begin
         hi_data_out = hi_regs_in;
         lo_data_out = lo_regs_in;
      end else begin
         hi_data_out = r_hi;
         lo_data_out = r_lo;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - table-driven scoreboard bench for wb_regfile
// Vectors are applied after the falling edge and sampled before the next rising edge.
module tb_wb_regfile;

   typedef struct {
      logic        rst_n;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        hilo_wen;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        r1_en;
      logic [4:0]  r1_addr;
      logic        r2_en;
      logic [4:0]  r2_addr;
      logic [31:0] exp_r1;
      logic [31:0] exp_r2;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [4:0]  w_reg_addr_in;
   logic [31:0] w_reg_data_in;
   logic        w_reg_en_in;
   logic [31:0] hi_regs_in;
   logic [31:0] lo_regs_in;
   logic        hilo_wen_in;
   logic        r1_en;
   logic [4:0]  r1_addr;
   logic [31:0] r1_data;
   logic        r2_en;
   logic [4:0]  r2_addr;
   logic [31:0] r2_data;
   logic [31:0] hi_data_out;
   logic [31:0] lo_data_out;

   int   n_cmp;
   int   n_fail;
   exp_t sb_q[$];
   vec_t vecs[$];

   wb_regfile #(
      .REG_ADDR_WIDTH(5),
      .REG_DATA_WIDTH(32),
      .REG_NUM       (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_reg_addr_in(w_reg_addr_in),
      .w_reg_data_in(w_reg_data_in),
      .w_reg_en_in  (w_reg_en_in),
      .hi_regs_in   (hi_regs_in),
      .lo_regs_in   (lo_regs_in),
      .hilo_wen_in  (hilo_wen_in),
      .r1_en        (r1_en),
      .r1_addr      (r1_addr),
      .r1_data      (r1_data),
      .r2_en        (r2_en),
      .r2_addr      (r2_addr),
      .r2_data      (r2_data),
      .hi_data_out  (hi_data_out),
      .lo_data_out  (lo_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string name, input logic rst, input logic wen,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic hwen, input logic [31:0] hi, input logic [31:0] lo,
                               input logic e1, input logic [4:0] a1,
                               input logic e2, input logic [4:0] a2,
                               input logic [31:0] x1, input logic [31:0] x2,
                               input logic [31:0] xhi, input logic [31:0] xlo);
      vec_t v;
      v.name = name; v.rst_n = rst; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
      v.hilo_wen = hwen; v.hi = hi; v.lo = lo;
      v.r1_en = e1; v.r1_addr = a1; v.r2_en = e2; v.r2_addr = a2;
      v.exp_r1 = x1; v.exp_r2 = x2; v.exp_hi = xhi; v.exp_lo = xlo;
      return v;
   endfunction

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", what, act, req);
      end
   endtask

   // Drive a vector, queue its expectation, then pop and compare 1 time unit later.
   task automatic apply(input vec_t v);
      exp_t e;
      rst_n         = v.rst_n;
      w_reg_en_in   = v.wen;
      w_reg_addr_in = v.waddr;
      w_reg_data_in = v.wdata;
      hilo_wen_in   = v.hilo_wen;
      hi_regs_in    = v.hi;
      lo_regs_in    = v.lo;
      r1_en         = v.r1_en;
      r1_addr       = v.r1_addr;
      r2_en         = v.r2_en;
      r2_addr       = v.r2_addr;
      e.r1 = v.exp_r1; e.r2 = v.exp_r2; e.hi = v.exp_hi; e.lo = v.exp_lo; e.name = v.name;
      sb_q.push_back(e);
      #1;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb_q.pop_front();
         check({e.name, ".r1"}, r1_data, e.r1);
         check({e.name, ".r2"}, r2_data, e.r2);
         check({e.name, ".hi"}, hi_data_out, e.hi);
         check({e.name, ".lo"}, lo_data_out, e.lo);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n = 1'b0; w_reg_en_in = 1'b0; w_reg_addr_in = '0; w_reg_data_in = '0;
      hilo_wen_in = 1'b0; hi_regs_in = '0; lo_regs_in = '0;
      r1_en = 1'b0; r1_addr = '0; r2_en = 1'b0; r2_addr = '0;

      //        name         rst wen wa  wdata         hw hi            lo            e1 a1  e2 a2  exp_r1        exp_r2        exp_hi        exp_lo
      vecs.push_back(mk("rst_wr_ign", 0, 1, 5, 32'h0000_0011, 1, 32'h0000_0022, 32'h0000_0033, 1, 5,  1, 31, 32'h0,         32'h0,         32'h0,         32'h0));
      vecs.push_back(mk("post_rst",   1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 5,  1, 31, 32'h0,         32'h0,         32'h0,         32'h0));
      vecs.push_back(mk("wr3_byp",    1, 1, 3, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,         0, 3,  1, 3,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0));
      vecs.push_back(mk("rd3",        1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 3,  0, 3,  32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0));
      vecs.push_back(mk("wr7_byp",    1, 1, 7, 32'h1234_5678, 0, 32'h0,         32'h0,         1, 7,  1, 7,  32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0));
      vecs.push_back(mk("rd7",        1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 7,  1, 7,  32'h1234_5678, 32'h1234_5678, 32'h0,         32'h0));
      vecs.push_back(mk("wr0",        1, 1, 0, 32'hFFFF_FFFF, 0, 32'h0,         32'h0,         1, 0,  1, 0,  32'h0,         32'h0,         32'h0,         32'h0));
      vecs.push_back(mk("rd0",        1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 0,  1, 3,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'h0));
      vecs.push_back(mk("hilo_gpr9",  1, 1, 9, 32'h0000_0005, 1, 32'hAAAA_0000, 32'h0000_BBBB, 1, 9,  1, 7,  32'h0000_0005, 32'h1234_5678, 32'hAAAA_0000, 32'h0000_BBBB));
      vecs.push_back(mk("hilo_hold",  1, 0, 0, 32'h0,         0, 32'h5555_5555, 32'h6666_6666, 1, 9,  1, 31, 32'h0000_0005, 32'h0,         32'hAAAA_0000, 32'h0000_BBBB));
      vecs.push_back(mk("ovr3_byp",   1, 1, 3, 32'h0000_0033, 0, 32'h0,         32'h0,         1, 3,  1, 3,  32'h0000_0033, 32'h0000_0033, 32'hAAAA_0000, 32'h0000_BBBB));
      vecs.push_back(mk("wr4_hi1",    1, 1, 4, 32'h0000_0077, 1, 32'h0000_0001, 32'h0000_0002, 1, 4,  1, 3,  32'h0000_0077, 32'h0000_0033, 32'h0000_0001, 32'h0000_0002));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         apply(vecs[i]);
      end

      // Reset pulsed between edges with a write pending; the write is lost.
      @(negedge clk);
      apply(mk("pre_pulse",  1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 4, 1, 3, 32'h0000_0077, 32'h0000_0033, 32'h0000_0001, 32'h0000_0002));
      apply(mk("in_pulse",   0, 1, 4, 32'h0000_0099, 1, 32'h0000_00AA, 32'h0000_00BB, 1, 4, 1, 4, 32'h0,         32'h0,         32'h0,         32'h0));
      apply(mk("rel_byp6",   1, 1, 6, 32'h0000_0066, 0, 32'h0,         32'h0,         1, 4, 1, 6, 32'h0,         32'h0000_0066, 32'h0,         32'h0));
      @(negedge clk);
      apply(mk("after_rel",  1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 4, 1, 6, 32'h0,         32'h0000_0066, 32'h0,         32'h0));

      // Reset held across a rising edge with writes active.
      @(negedge clk);
      apply(mk("rst_edge",   0, 1, 6, 32'h0000_0123, 1, 32'h0000_0456, 32'h0000_0789, 1, 6, 1, 9, 32'h0,         32'h0,         32'h0,         32'h0));
      @(negedge clk);
      apply(mk("rst_edge_q", 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         1, 6, 1, 9, 32'h0,         32'h0,         32'h0,         32'h0));

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
